// File: rtl/sensor_poller_pkg.sv
// Shared constants for the accelerometer poller: register map, configuration
// table, FSM encodings and table lookups.
package sensor_poller_pkg;

    localparam int CFG_LEN = 3;
    localparam int RD_LEN  = 6;

    localparam logic [5:0] REG_BW_RATE     = 6'h2C;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [5:0] REG_DATAX0      = 6'h32;

    localparam logic [7:0] VAL_BW_RATE     = 8'h0A;
    localparam logic [7:0] VAL_DATA_FORMAT = 8'h0B;
    localparam logic [7:0] VAL_POWER_CTL   = 8'h08;

    typedef enum logic [2:0] {
        ST_WAIT_START,
        ST_CFG_ISSUE,
        ST_CFG_XFER,
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_XFER,
        ST_PUBLISH,
        ST_ERROR
    } poll_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_ACK,
        PH_DONE,
        PH_DRAIN
    } phase_t;

    function automatic logic [5:0] cfg_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    return REG_BW_RATE;
            3'd1:    return REG_DATA_FORMAT;
            default: return REG_POWER_CTL;
        endcase
    endfunction

    function automatic logic [7:0] cfg_data(input logic [2:0] idx);
        case (idx)
            3'd0:    return VAL_BW_RATE;
            3'd1:    return VAL_DATA_FORMAT;
            default: return VAL_POWER_CTL;
        endcase
    endfunction

endpackage

// File: rtl/sensor_poller_handshake.sv
// One SPI byte transaction: request/ack/complete handshake against the master's
// busy flag, with busy synchroniser and per-phase timeout.
module spi_txn_handshake
    import sensor_poller_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [5:0] address,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic       timeout,
    output logic [7:0] rdata,
    output logic       spi_en,
    output logic       spi_rw,
    output logic [5:0] spi_address,
    output logic [7:0] spi_wdata,
    input  logic [7:0] spi_rdata,
    input  logic       spi_busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    phase_t           phase, phase_nxt;
    logic [CNT_W-1:0] phase_cnt;
    logic             busy_meta, busy_sync;
    logic             at_limit;

    // busy toggles in the master's generated clock domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
        end else begin
            busy_meta <= spi_busy;
            busy_sync <= busy_meta;
        end
    end

    assign at_limit = (phase_cnt == CNT_W'(TIMEOUT - 1));
    assign ready    = (phase == PH_IDLE);
    assign rdata    = spi_rdata;

    always_comb begin
        phase_nxt = phase;
        done      = 1'b0;
        timeout   = 1'b0;
        case (phase)
            PH_IDLE: begin
                if (start) phase_nxt = PH_ACK;
            end
            PH_ACK: begin
                if (busy_sync) begin
                    phase_nxt = PH_DONE;
                end else if (at_limit) begin
                    timeout   = 1'b1;
                    phase_nxt = PH_DRAIN;
                end
            end
            PH_DONE: begin
                if (!busy_sync) begin
                    done      = 1'b1;
                    phase_nxt = PH_IDLE;
                end else if (at_limit) begin
                    timeout   = 1'b1;
                    phase_nxt = PH_DRAIN;
                end
            end
            PH_DRAIN: begin
                if (!busy_sync) phase_nxt = PH_IDLE;
            end
            default: phase_nxt = PH_IDLE;
        endcase
    end

    // spi_en is simply "next phase is ACK": rises on start, falls on ack or timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase       <= PH_IDLE;
            phase_cnt   <= '0;
            spi_en      <= 1'b0;
            spi_rw      <= 1'b0;
            spi_address <= '0;
            spi_wdata   <= '0;
        end else begin
            phase  <= phase_nxt;
            spi_en <= (phase_nxt == PH_ACK);
            if (phase_nxt != phase) begin
                phase_cnt <= '0;
            end else if (!at_limit) begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end
            if (start && phase == PH_IDLE) begin
                spi_rw      <= rw;
                spi_address <= address;
                spi_wdata   <= wdata;
            end
        end
    end

endmodule

// File: rtl/sensor_poller.sv
// Accelerometer poller: writes the configuration table once, then reads the
// six axis bytes on every sample tick and publishes signed X/Y/Z samples.
module sensor_poller
    import sensor_poller_pkg::*;
#(
    parameter int SAMPLE_DIV     = 100000,
    parameter int STARTUP_CYCLES = 1000,
    parameter int TIMEOUT        = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        spi_en,
    output logic        spi_rw,
    output logic [5:0]  spi_address,
    output logic [7:0]  spi_wdata,
    input  logic [7:0]  spi_rdata,
    input  logic        spi_busy,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [15:0] z,
    output logic        sample_valid,
    output logic        cfg_done,
    output logic        error,
    output logic [7:0]  overrun_cnt
);

    localparam int TMR_W = $clog2(SAMPLE_DIV);

    poll_state_t      state, state_nxt;
    logic [2:0]       idx;
    logic [31:0]      start_cnt;
    logic [TMR_W-1:0] tmr;
    logic             tick;
    logic [7:0]       rd_bytes [RD_LEN];

    logic             hs_start, hs_rw;
    logic [5:0]       hs_addr;
    logic [7:0]       hs_wdata, hs_rdata;
    logic             hs_ready, hs_done, hs_timeout;

    spi_txn_handshake #(.TIMEOUT(TIMEOUT)) u_handshake (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (hs_start),
        .rw          (hs_rw),
        .address     (hs_addr),
        .wdata       (hs_wdata),
        .ready       (hs_ready),
        .done        (hs_done),
        .timeout     (hs_timeout),
        .rdata       (hs_rdata),
        .spi_en      (spi_en),
        .spi_rw      (spi_rw),
        .spi_address (spi_address),
        .spi_wdata   (spi_wdata),
        .spi_rdata   (spi_rdata),
        .spi_busy    (spi_busy)
    );

    assign tick = cfg_done && (tmr == TMR_W'(SAMPLE_DIV - 1));

    always_comb begin
        state_nxt = state;
        hs_start  = 1'b0;
        hs_rw     = 1'b0;
        hs_addr   = '0;
        hs_wdata  = '0;
        case (state)
            ST_WAIT_START: begin
                if (start_cnt == 32'(STARTUP_CYCLES - 1)) state_nxt = ST_CFG_ISSUE;
            end
            ST_CFG_ISSUE: begin
                hs_start  = 1'b1;
                hs_addr   = cfg_addr(idx);
                hs_wdata  = cfg_data(idx);
                state_nxt = ST_CFG_XFER;
            end
            ST_CFG_XFER: begin
                if (hs_timeout)   state_nxt = ST_ERROR;
                else if (hs_done) state_nxt = (idx == 3'(CFG_LEN - 1)) ? ST_IDLE : ST_CFG_ISSUE;
            end
            ST_IDLE: begin
                if (tick && run) state_nxt = ST_RD_ISSUE;
            end
            ST_RD_ISSUE: begin
                hs_start  = 1'b1;
                hs_rw     = 1'b1;
                hs_addr   = REG_DATAX0 + {3'b000, idx};
                state_nxt = ST_RD_XFER;
            end
            ST_RD_XFER: begin
                if (hs_timeout)   state_nxt = ST_ERROR;
                else if (hs_done) state_nxt = (idx == 3'(RD_LEN - 1)) ? ST_PUBLISH : ST_RD_ISSUE;
            end
            ST_PUBLISH: state_nxt = ST_IDLE;
            ST_ERROR: begin
                if (hs_ready) state_nxt = ST_CFG_ISSUE;
            end
            default: state_nxt = ST_WAIT_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_WAIT_START;
            idx          <= '0;
            start_cnt    <= '0;
            tmr          <= '0;
            cfg_done     <= 1'b0;
            error        <= 1'b0;
            overrun_cnt  <= '0;
            sample_valid <= 1'b0;
            x            <= '0;
            y            <= '0;
            z            <= '0;
        end else begin
            state        <= state_nxt;
            sample_valid <= (state == ST_PUBLISH);
            start_cnt    <= (state == ST_WAIT_START) ? start_cnt + 32'd1 : '0;

            if (state == ST_PUBLISH) begin
                x <= {rd_bytes[1], rd_bytes[0]};
                y <= {rd_bytes[3], rd_bytes[2]};
                z <= {rd_bytes[5], rd_bytes[4]};
            end

            if (hs_timeout) begin
                error    <= 1'b1;
                cfg_done <= 1'b0;
                idx      <= '0;
            end else if (hs_done && state == ST_CFG_XFER) begin
                if (idx == 3'(CFG_LEN - 1)) begin
                    idx      <= '0;
                    cfg_done <= 1'b1;
                end else begin
                    idx <= idx + 3'd1;
                end
            end else if (hs_done && state == ST_RD_XFER) begin
                idx <= (idx == 3'(RD_LEN - 1)) ? 3'd0 : idx + 3'd1;
            end

            // timer free-runs only while configured; a busy FSM drops the tick
            if (!cfg_done || tick) tmr <= '0;
            else                   tmr <= tmr + TMR_W'(1);

            if (tick && state != ST_IDLE && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_RD_XFER && hs_done) rd_bytes[idx] <= hs_rdata;
    end

endmodule

// File: tb/tb_sensor_poller.sv
// Directed bench for sensor_poller with a behavioural byte-transaction SPI slave.
module tb_sensor_poller;

    localparam int SAMPLE_DIV = 128;
    localparam int STARTUP    = 20;
    localparam int TMO        = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        spi_en, spi_rw;
    logic [5:0]  spi_address;
    logic [7:0]  spi_wdata;
    logic [7:0]  spi_rdata = 8'h00;
    logic        spi_busy = 1'b0;
    logic [15:0] x, y, z;
    logic        sample_valid, cfg_done, error;
    logic [7:0]  overrun_cnt;

    int n_chk = 0;
    int n_pass = 0;

    sensor_poller #(.SAMPLE_DIV(SAMPLE_DIV), .STARTUP_CYCLES(STARTUP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .spi_en(spi_en), .spi_rw(spi_rw), .spi_address(spi_address), .spi_wdata(spi_wdata),
        .spi_rdata(spi_rdata), .spi_busy(spi_busy),
        .x(x), .y(y), .z(z), .sample_valid(sample_valid),
        .cfg_done(cfg_done), .error(error), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // Slave: accepts a request, holds busy for at least `hold` cycles and until spi_en drops.
    logic [7:0] mem [0:63];
    int         hold = 1;
    bit         dead = 1'b0;
    int         t_n = 0;
    logic       t_rw   [0:1023];
    logic [5:0] t_addr [0:1023];
    logic [7:0] t_wd   [0:1023];
    int         s_st = 0;
    int         s_cnt = 0;

    always @(posedge clk) begin
        if (s_st == 0) begin
            if (spi_en && !dead) begin
                spi_busy          <= 1'b1;
                spi_rdata         <= mem[spi_address];
                t_rw[t_n % 1024]   <= spi_rw;
                t_addr[t_n % 1024] <= spi_address;
                t_wd[t_n % 1024]   <= spi_wdata;
                t_n   <= t_n + 1;
                s_cnt <= 0;
                s_st  <= 1;
            end
        end else begin
            s_cnt <= s_cnt + 1;
            if (s_cnt >= hold && !spi_en) begin
                spi_busy <= 1'b0;
                s_st     <= 0;
            end
        end
    end

    task automatic test_reset();
        int base;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (spi_en !== 1'b0)       $display("FAIL reset_spi_en got %0h want 0", spi_en); else n_pass++;
        n_chk++; if (spi_rw !== 1'b0)       $display("FAIL reset_spi_rw got %0h want 0", spi_rw); else n_pass++;
        n_chk++; if (spi_address !== 6'h00) $display("FAIL reset_spi_address got %0h want 0", spi_address); else n_pass++;
        n_chk++; if (spi_wdata !== 8'h00)   $display("FAIL reset_spi_wdata got %0h want 0", spi_wdata); else n_pass++;
        n_chk++; if (x !== 16'h0 || y !== 16'h0 || z !== 16'h0) $display("FAIL reset_xyz got %0h %0h %0h want 0 0 0", x, y, z); else n_pass++;
        n_chk++; if (sample_valid !== 1'b0) $display("FAIL reset_sample_valid got %0h want 0", sample_valid); else n_pass++;
        n_chk++; if (cfg_done !== 1'b0)     $display("FAIL reset_cfg_done got %0h want 0", cfg_done); else n_pass++;
        n_chk++; if (error !== 1'b0)        $display("FAIL reset_error got %0h want 0", error); else n_pass++;
        n_chk++; if (overrun_cnt !== 8'h00) $display("FAIL reset_overrun got %0h want 0", overrun_cnt); else n_pass++;
        base = t_n;
        rst_n = 1'b1;
        repeat (STARTUP - 2) @(negedge clk);
        n_chk++; if (spi_en !== 1'b0 || t_n != base) $display("FAIL startup_quiet got en=%0h txns=%0d want en=0 txns=0", spi_en, t_n - base); else n_pass++;
    endtask

    task automatic test_config();
        logic [5:0] ea [3] = '{6'h2C, 6'h31, 6'h2D};
        logic [7:0] ed [3] = '{8'h0A, 8'h0B, 8'h08};
        int base;
        bit ok;
        base = t_n - 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok) $display("FAIL cfg_done_wait got timeout want cfg_done=1"); else n_pass++;
        n_chk++; if (t_n != 3) $display("FAIL cfg_txn_count got %0d want 3", t_n); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (t_rw[k] !== 1'b0 || t_addr[k] !== ea[k] || t_wd[k] !== ed[k])
                $display("FAIL cfg_write_%0d got rw=%0h addr=%0h data=%0h want rw=0 addr=%0h data=%0h",
                         k, t_rw[k], t_addr[k], t_wd[k], ea[k], ed[k]);
            else n_pass++;
        end
        n_chk++; if (error !== 1'b0) $display("FAIL cfg_error got %0h want 0", error); else n_pass++;
    endtask

    task automatic test_read();
        int base;
        bit ok;
        base = t_n;
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin ok = 1'b1; break; end
        end
        run = 1'b0;
        n_chk++; if (!ok) $display("FAIL read_valid_wait got timeout want sample_valid=1"); else n_pass++;
        n_chk++; if (x !== 16'h1234) $display("FAIL read_x got %0h want 1234", x); else n_pass++;
        n_chk++; if (y !== 16'hFFFE) $display("FAIL read_y got %0h want fffe", y); else n_pass++;
        n_chk++; if (z !== 16'h8000) $display("FAIL read_z got %0h want 8000", z); else n_pass++;
        n_chk++; if (t_n - base != 6) $display("FAIL read_txn_count got %0d want 6", t_n - base); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (t_rw[(base + k) % 1024] !== 1'b1 || t_addr[(base + k) % 1024] !== 6'(8'h32 + k))
                $display("FAIL read_addr_%0d got rw=%0h addr=%0h want rw=1 addr=%0h",
                         k, t_rw[(base + k) % 1024], t_addr[(base + k) % 1024], 8'h32 + k);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++; if (sample_valid !== 1'b0) $display("FAIL read_valid_pulse got %0h want 0", sample_valid); else n_pass++;
        n_chk++; if (overrun_cnt !== 8'h00) $display("FAIL read_overrun got %0h want 0", overrun_cnt); else n_pass++;
    endtask

    task automatic test_run_drop();
        int base;
        logic [7:0] ov;
        bit ok;
        mem[6'h32] = 8'h11; mem[6'h33] = 8'h22; mem[6'h34] = 8'h33;
        mem[6'h35] = 8'h44; mem[6'h36] = 8'h55; mem[6'h37] = 8'h66;
        base = t_n;
        ov = overrun_cnt;
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (t_n - base >= 2) begin ok = 1'b1; break; end
        end
        run = 1'b0;
        n_chk++; if (!ok) $display("FAIL drop_byte2_wait got timeout want second read"); else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok) $display("FAIL drop_valid_wait got timeout want sample_valid=1"); else n_pass++;
        n_chk++; if ({x, y, z} !== 48'h2211_4433_6655) $display("FAIL drop_xyz got %0h %0h %0h want 2211 4433 6655", x, y, z); else n_pass++;
        repeat (3 * SAMPLE_DIV) @(negedge clk);
        n_chk++; if (t_n - base != 6) $display("FAIL drop_no_new_burst got %0d txns want 6", t_n - base); else n_pass++;
        n_chk++; if (overrun_cnt !== ov) $display("FAIL drop_overrun got %0h want %0h", overrun_cnt, ov); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [7:0] ov0;
        int delta;
        bit ok;
        hold = 300;
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (overrun_cnt != 8'h00) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok) $display("FAIL ovr_first_wait got timeout want overrun_cnt>0"); else n_pass++;
        ov0 = overrun_cnt;
        repeat (10 * SAMPLE_DIV) @(negedge clk);
        delta = int'(overrun_cnt) - int'(ov0);
        n_chk++; if (delta < 9 || delta > 10) $display("FAIL ovr_per_tick got %0d want 9..10", delta); else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 45000; i++) begin
            @(negedge clk);
            if (overrun_cnt == 8'hFF) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok) $display("FAIL ovr_reach_255 got %0d want 255", overrun_cnt); else n_pass++;
        repeat (3 * SAMPLE_DIV) @(negedge clk);
        n_chk++; if (overrun_cnt !== 8'hFF) $display("FAIL ovr_saturate got %0h want ff", overrun_cnt); else n_pass++;
        run = 1'b0;
        hold = 1;
        repeat (2500) @(negedge clk);
    endtask

    task automatic test_timeout();
        int base;
        bit ok;
        dead = 1'b1;
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < SAMPLE_DIV + TMO + 100; i++) begin
            @(negedge clk);
            if (error === 1'b1) begin ok = 1'b1; break; end
        end
        run = 1'b0;
        n_chk++; if (!ok) $display("FAIL tmo_error_wait got timeout want error=1"); else n_pass++;
        n_chk++; if (spi_en !== 1'b0) $display("FAIL tmo_spi_en got %0h want 0", spi_en); else n_pass++;
        n_chk++; if (cfg_done !== 1'b0) $display("FAIL tmo_cfg_done got %0h want 0", cfg_done); else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (spi_en === 1'b1) begin ok = 1'b1; break; end
        end
        n_chk++;
        if (!ok || spi_rw !== 1'b0 || spi_address !== 6'h2C || spi_wdata !== 8'h0A)
            $display("FAIL tmo_cfg_restart got en=%0h rw=%0h addr=%0h data=%0h want 1 0 2c 0a", spi_en, spi_rw, spi_address, spi_wdata);
        else n_pass++;
        base = t_n;
        dead = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok || t_n - base != 3) $display("FAIL tmo_reconfig got done=%0h txns=%0d want 1 3", cfg_done, t_n - base); else n_pass++;
        n_chk++; if (error !== 1'b1) $display("FAIL tmo_error_sticky got %0h want 1", error); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int base;
        bit ok;
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (spi_en === 1'b1 && spi_address === 6'h34) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok) $display("FAIL rst_byte3_wait got timeout want read of 0x34"); else n_pass++;
        rst_n = 1'b0;
        run = 1'b0;
        @(negedge clk);
        n_chk++; if (spi_en !== 1'b0 || spi_rw !== 1'b0 || spi_address !== 6'h00 || spi_wdata !== 8'h00)
            $display("FAIL rst_mid_spi got en=%0h rw=%0h addr=%0h data=%0h want 0 0 0 0", spi_en, spi_rw, spi_address, spi_wdata);
        else n_pass++;
        n_chk++; if (x !== 16'h0 || y !== 16'h0 || z !== 16'h0) $display("FAIL rst_mid_xyz got %0h %0h %0h want 0 0 0", x, y, z); else n_pass++;
        n_chk++; if (cfg_done !== 1'b0 || error !== 1'b0 || sample_valid !== 1'b0)
            $display("FAIL rst_mid_flags got done=%0h err=%0h vld=%0h want 0 0 0", cfg_done, error, sample_valid);
        else n_pass++;
        n_chk++; if (overrun_cnt !== 8'h00) $display("FAIL rst_mid_overrun got %0h want 0", overrun_cnt); else n_pass++;
        rst_n = 1'b1;
        base = t_n;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok || t_n - base != 3) $display("FAIL rst_reconfig got done=%0h txns=%0d want 1 3", cfg_done, t_n - base); else n_pass++;
        n_chk++; if (t_addr[base % 1024] !== 6'h2C || t_addr[(base + 2) % 1024] !== 6'h2D)
            $display("FAIL rst_reconfig_order got %0h..%0h want 2c..2d", t_addr[base % 1024], t_addr[(base + 2) % 1024]);
        else n_pass++;
    endtask

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = 8'h00;
        mem[6'h32] = 8'h34; mem[6'h33] = 8'h12; mem[6'h34] = 8'hFE;
        mem[6'h35] = 8'hFF; mem[6'h36] = 8'h00; mem[6'h37] = 8'h80;
        test_reset();
        test_config();
        test_read();
        test_run_drop();
        test_overrun();
        test_timeout();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
